intersect_result_writer: RTL

// - Consumer end of the block-intersection result stream (x, y, best_block, best_t, valid).
// - Converts each result to a framebuffer write (pixel address + RGB444 colour).
// - Buffers writes in a FIFO and drains them to a ready/valid memory write port.
// - Upstream has no backpressure: overflow drops the result and is reported, never stalls.

---
 rtl/intersect_result_writer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/intersect_result_writer.sv
// intersect_result_writer
// Turns block-intersection results into framebuffer writes (address + RGB444),
// buffers them in a small FIFO and drains them over a ready/valid write port.
// The result stream cannot be stalled, so a full FIFO drops the result and
// records the loss in a sticky flag and a saturating counter.
module intersect_result_writer #(
  parameter int         H_RES      = 320,
  parameter int         V_RES      = 180,
  parameter int         FIFO_DEPTH = 16,
  parameter int         ADDR_W     = 16,
  parameter logic [3:0] MISS_BLOCK = 4'd15,
  parameter logic [11:0] BG_COLOR  = 12'h000
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [10:0]       x_in,
  input  logic [9:0]        y_in,
  input  logic [3:0]        best_block_in,
  input  logic [31:0]       best_t_in,
  input  logic              valid_in,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [11:0]       wr_data_out,
  output logic              wr_valid_out,
  input  logic              wr_ready_in,
  output logic              frame_done_out,
  output logic              overflow_out,
  output logic [15:0]       dropped_count_out
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = 1 + 12 + ADDR_W;  // {last_pixel, colour, address}

  // Only the sign of the ray parameter matters: negative t counts as a miss.
  logic unused_t_bits;
  assign unused_t_bits = ^best_t_in[30:0];

  logic              in_range;
  logic              is_hit;
  logic              is_last;
  logic [11:0]       color_next;
  logic [ADDR_W-1:0] addr_next;

  assign in_range  = (32'(x_in) < 32'(H_RES)) && (32'(y_in) < 32'(V_RES));
  assign is_hit    = (best_block_in != MISS_BLOCK) && !best_t_in[31];
  assign is_last   = (32'(x_in) == 32'(H_RES - 1)) && (32'(y_in) == 32'(V_RES - 1));
  // Computing directly in ADDR_W bits gives the same result as truncating the full product.
  assign addr_next = ADDR_W'(y_in) * ADDR_W'(H_RES) + ADDR_W'(x_in);

  // Palette lookup: the two low bits of the block index select the hit colour.
  always_comb begin
    color_next = BG_COLOR;
    if (is_hit) begin
      case (best_block_in[1:0])
        2'd0:    color_next = 12'hF00;
        2'd1:    color_next = 12'h0F0;
        2'd2:    color_next = 12'h00F;
        default: color_next = 12'hFF0;
      endcase
    end
  end

  logic               s1_valid_reg;
  logic [ENTRY_W-1:0] s1_entry_reg;

  // Stage 1: register the filtered, converted result.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_valid_reg <= 1'b0;
      s1_entry_reg <= '0;
    end else begin
      s1_valid_reg <= valid_in && in_range;
      s1_entry_reg <= {is_last, color_next, addr_next};
    end
  end

  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W:0]     count_reg;
  logic [PTR_W:0]     count_next;
  logic               frame_done_reg;
  logic               overflow_reg;
  logic [15:0]        dropped_reg;
  logic [ENTRY_W-1:0] head_entry;
  logic               fifo_full;
  logic               push;
  logic               pop;
  logic               drop;

  assign fifo_full  = (count_reg == (PTR_W + 1)'(FIFO_DEPTH));
  assign head_entry = fifo_mem[rd_ptr_reg];
  assign pop        = wr_valid_out && wr_ready_in;
  // A same-cycle pop frees a slot, so a full FIFO still accepts the entry.
  assign push       = s1_valid_reg && (!fifo_full || pop);
  assign drop       = s1_valid_reg && fifo_full && !pop;

  // Occupancy update from the push/pop pair.
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // FIFO storage; contents are never reset because occupancy alone defines validity.
  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= s1_entry_reg;
    end
  end

  // FIFO pointers, occupancy, frame-done pulse and drop accounting.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      frame_done_reg <= 1'b0;
      overflow_reg   <= 1'b0;
      dropped_reg    <= 16'd0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg      <= count_next;
      frame_done_reg <= pop && head_entry[ENTRY_W-1];
      if (drop) begin
        overflow_reg <= 1'b1;
        if (dropped_reg != 16'hFFFF) begin
          dropped_reg <= dropped_reg + 16'd1;
        end
      end
    end
  end

  // Head entry is shown only while valid so the port reads as zero when idle.
  assign wr_valid_out      = (count_reg != '0);
  assign wr_addr_out       = wr_valid_out ? head_entry[ADDR_W-1:0] : '0;
  assign wr_data_out       = wr_valid_out ? head_entry[ADDR_W +: 12] : 12'h000;
  assign frame_done_out    = frame_done_reg;
  assign overflow_out      = overflow_reg;
  assign dropped_count_out = dropped_reg;

endmodule
